seq_multiplier: RTL

Parametrised sequential shift-add multiplier with a shared tristate data bus. It is the multi-cycle successor to the single-cycle combinational multiplier block. It adds a start/ready handshake, a signed (two's complement) mode and write-enable-qualified operand loading. It sits on the same n-bit bus as the combinational version and is driven by the same func/oe command encoding. It produces a 2n-bit product in n clock cycles.

---
 rtl/seq_multiplier.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (unsigned or two's complement) on a shared tristate bus.
// n-bit operands are loaded over the bus, and the 2n-bit product is ready n cycles after start.
//
// state | meaning
// IDLE  | ready=1, operand loads accepted, start accepted
// BUSY  | ready=0, one shift-add step per cycle, loads/start ignored
module seq_multiplier #(
   parameter int n = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       sgn,
   input  logic [1:0] func,
   input  logic       we,
   input  logic       oe,
   output logic       ready,
   inout  wire  [n-1:0] data
);

   localparam int CW = $clog2(n) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [n-1:0]  m_reg;
   logic [n-1:0]  qin_reg;
   logic [n:0]    a_reg;
   logic [n-1:0]  q_reg;
   logic [CW-1:0] count;
   logic          mode;

   logic          last_step;
   logic [n:0]    mx;
   logic [n:0]    a_op;
   logic [n:0]    sum;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = BUSY;
         end
         BUSY: begin
            if (last_step) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // In unsigned mode A[n] only mirrors the last carry, so the add uses the low n bits
   // zero-extended; the carry out then lands in sum[n].
   always_comb begin
      last_step = (count == CW'(n - 1));
      mx        = mode ? {m_reg[n-1], m_reg} : {1'b0, m_reg};
      a_op      = mode ? a_reg : {1'b0, a_reg[n-1:0]};
      sum       = a_op;
      if (q_reg[0]) begin
         if (mode && last_step) sum = a_op - mx;
         else                   sum = a_op + mx;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_reg   <= '0;
         qin_reg <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         count   <= '0;
         mode    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (we && func == 2'b00) m_reg   <= data;
               if (we && func == 2'b01) qin_reg <= data;
               if (start) begin
                  a_reg <= '0;
                  q_reg <= qin_reg;
                  count <= '0;
                  mode  <= sgn;
               end
            end
            BUSY: begin
               a_reg <= {sum[n], sum[n:1]};
               q_reg <= {sum[0], q_reg[n-1:1]};
               count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign data = (oe && func == 2'b10) ? q_reg :
                 (oe && func == 2'b11) ? a_reg[n-1:0] :
                 {n{1'bz}};

endmodule
